// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex driver for a DIGITS-wide common-anode 7-segment display.
// Latency: seg_n/dig_en_n/frame_start are registered, one clock behind the refresh counter and digit index.
// Backpressure: none; load is always accepted, the newest load wins until the next frame boundary.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   value, dots       hex nibbles (digit 0 rightmost) and per-digit decimal-point requests
//   load              capture value/dots into the pending buffer this cycle
//   lz_suppress       blank leading zeros (live, not buffered)
//   seg_n             {dp,g,f,e,d,c,b,a}, active-low
//   dig_en_n          anode select, one-hot-low
//   frame_start       one-clock pulse after the digit index wraps to 0
module hex_display_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  load,
    input  logic                  lz_suppress,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     dig_en_n,
    output logic                  frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    pend_val;
    logic [DIGITS-1:0]      pend_dots;
    logic                   pend_vld;
    logic [4*DIGITS-1:0]    shadow_val;
    logic [DIGITS-1:0]      shadow_dots;

    logic                   cnt_wrap;
    logic                   frame_bnd;

    assign cnt_wrap  = (cnt == CNT_LAST);
    // With DIGITS=1 IDX_LAST is 0, so every wrap is a frame boundary.
    assign frame_bnd = cnt_wrap && (idx == IDX_LAST);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Select the current digit's nibble/dot via a compare loop so a
    // non-power-of-two DIGITS never produces an out-of-range index.
    logic [3:0]         cur_nib;
    logic               cur_dot;
    logic [DIGITS-1:0]  dig_sel;

    always_comb begin
        cur_nib = 4'h0;
        cur_dot = 1'b0;
        dig_sel = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib    = shadow_val[4*k +: 4];
                cur_dot    = shadow_dots[k];
                dig_sel[k] = 1'b1;
            end
        end
    end

    // lz_mask[k] is set when nibble k and every more-significant nibble are zero.
    // Bit 0 stays clear: the rightmost digit always shows.
    logic [DIGITS-1:0]  lz_mask;
    logic               zero_run;

    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (shadow_val[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    logic cur_supp;
    assign cur_supp = lz_suppress && |(lz_mask & dig_sel);

    // Refresh counter, digit index and the pending/shadow double buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            pend_val    <= '0;
            pend_dots   <= '0;
            pend_vld    <= 1'b0;
            shadow_val  <= '0;
            shadow_dots <= '0;
        end else begin
            if (cnt_wrap) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (load) begin
                pend_val  <= value;
                pend_dots <= dots;
            end

            // A load on the boundary cycle goes straight to shadow so it
            // shows in the frame that is just starting.
            if (frame_bnd && (pend_vld || load)) begin
                shadow_val  <= load ? value : pend_val;
                shadow_dots <= load ? dots  : pend_dots;
                pend_vld    <= 1'b0;
            end else if (load) begin
                pend_vld    <= 1'b1;
            end
        end
    end

    // Registered pin drivers. Segments keep tracking idx during the blank
    // window; only the anodes are held off to hide the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n       <= 8'hFF;
            dig_en_n    <= '1;
            frame_start <= 1'b0;
        end else begin
            seg_n       <= {~cur_dot, cur_supp ? 7'h7F : hex7(cur_nib)};
            dig_en_n    <= (cnt < BLANK_END) ? '1 : ~dig_sel;
            frame_start <= frame_bnd;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

    localparam int DIGITS = 4;
    localparam int RDIV   = 8;
    localparam int BLANK  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dots  = '0;
    logic        load  = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [7:0]  seg_n;
    logic [3:0]  dig_en_n;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hex_display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dots        (dots),
        .load        (load),
        .lz_suppress (lz_suppress),
        .seg_n       (seg_n),
        .dig_en_n    (dig_en_n),
        .frame_start (frame_start)
    );

    // Segment patterns (g..a, active-low) for nibbles 0..F.
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Time is counted in clocks since reset; slot/digit follow by division.
    // Expected outputs are those derived from the state before each edge.
    int          t;
    logic [15:0] m_sh, m_pv;
    logic [3:0]  m_sd, m_pd;
    bit          m_pf;
    logic [7:0]  e_seg;
    logic [3:0]  e_en;
    logic        e_fs;

    function automatic bit lead_zero(input logic [15:0] v, input int d);
        if (d == 0) return 1'b0;
        return (v >> (4*d)) == 16'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int         c, d;
        bit         bnd;
        logic [3:0] nib;
        if (!rst_n) begin
            t = 0; m_sh = '0; m_pv = '0; m_sd = '0; m_pd = '0; m_pf = 0;
            e_seg = 8'hFF; e_en = 4'hF; e_fs = 1'b0;
        end else begin
            c   = t % RDIV;
            d   = (t / RDIV) % DIGITS;
            nib = 4'((m_sh >> (4*d)) & 16'hF);
            e_seg[7]   = ~m_sd[d];
            e_seg[6:0] = (lz_suppress && lead_zero(m_sh, d)) ? 7'h7F : seg_tab[nib];
            e_en       = (c < BLANK) ? 4'hF : ~(4'b0001 << d);
            bnd        = (c == RDIV-1) && (d == DIGITS-1);
            e_fs       = bnd;
            if (bnd && (m_pf || load)) begin
                m_sh = load ? value : m_pv;
                m_sd = load ? dots  : m_pd;
                m_pf = 0;
            end
            if (load) begin
                m_pv = value;
                m_pd = dots;
                if (!bnd) m_pf = 1;
            end
            t++;
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            check("model seg_n",       32'(seg_n),       32'(e_seg));
            check("model dig_en_n",    32'(dig_en_n),    32'(e_en));
            check("model frame_start", 32'(frame_start), 32'(e_fs));
        end
    end

    // ---------------- directed helpers ----------------
    logic [7:0] fr_seg   [4];
    logic [3:0] fr_en    [4];
    logic [3:0] fr_blank [4];

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 100);
        tests++;
        if (!frame_start) begin
            fails++;
            $display("FAIL frame_start wait: no pulse within %0d clocks", n);
        end
    endtask

    // Called at the frame_start cycle (slot 0, count 0); ends on the boundary cycle.
    task automatic grab_rest();
        for (int p = 1; p < 32; p++) begin
            @(negedge clk);
            if (p % 8 == 1) fr_blank[p/8] = dig_en_n;
            if (p % 8 == 5) begin
                fr_seg[p/8] = seg_n;
                fr_en[p/8]  = dig_en_n;
            end
        end
    endtask

    task automatic grab_frame();
        wait_frame();
        grab_rest();
    endtask

    task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        check({tag, " d0"}, 32'(fr_seg[0]), 32'(s0));
        check({tag, " d1"}, 32'(fr_seg[1]), 32'(s1));
        check({tag, " d2"}, 32'(fr_seg[2]), 32'(s2));
        check({tag, " d3"}, 32'(fr_seg[3]), 32'(s3));
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dots  = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fs_cnt, fs_run, fs_max;
        logic [15:0] rv;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset seg_n",       32'(seg_n),       32'h0FF);
        check("reset dig_en_n",    32'(dig_en_n),    32'hF);
        check("reset frame_start", 32'(frame_start), 32'h0);
        chk_on = 1;
        rst_n  = 1'b1;

        // Plain decode and anode sequencing over two frames.
        load_val(16'h1A3F, 4'b0000);
        for (int f = 0; f < 2; f++) begin
            grab_frame();
            check_frame("1A3F", 8'h8E, 8'hB0, 8'h88, 8'hF9);
            check("anode d0", 32'(fr_en[0]), 32'hE);
            check("anode d1", 32'(fr_en[1]), 32'hD);
            check("anode d2", 32'(fr_en[2]), 32'hB);
            check("anode d3", 32'(fr_en[3]), 32'h7);
            for (int k = 0; k < 4; k++) check("blank window", 32'(fr_blank[k]), 32'hF);
        end

        // Leading-zero suppression.
        lz_suppress = 1'b1;
        load_val(16'h0070, 4'b0000);
        grab_frame();
        check_frame("lz 0070", 8'hC0, 8'hF8, 8'hFF, 8'hFF);
        load_val(16'h0000, 4'b0000);
        grab_frame();
        check_frame("lz 0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // Load on the boundary cycle applies to the frame just starting.
        lz_suppress = 1'b0;
        load_val(16'hC0DE, 4'b0000);
        check("boundary frame_start", 32'(frame_start), 32'h1);
        grab_rest();
        check_frame("boundary C0DE", 8'h86, 8'hA1, 8'hC0, 8'hC6);

        // Load during the digit-1 slot: rest of the frame keeps the old value.
        @(negedge clk);
        repeat (10) @(negedge clk);
        load_val(16'h1234, 4'b0000);
        for (int p = 12; p < 32; p++) begin
            @(negedge clk);
            if (p == 21) check("mid load old d2", 32'(seg_n), 32'h0C0);
            if (p == 29) check("mid load old d3", 32'(seg_n), 32'h0C6);
        end
        grab_frame();
        check_frame("1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // frame_start: single-clock pulse every 32 clocks.
        fs_cnt = 0; fs_run = 0; fs_max = 0;
        for (int p = 0; p < 64; p++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_cnt++;
                fs_run++;
                if (fs_run > fs_max) fs_max = fs_run;
            end else begin
                fs_run = 0;
            end
        end
        check("frame_start count", 32'(fs_cnt), 32'd2);
        check("frame_start width", 32'(fs_max), 32'd1);

        // Two loads in one frame: the second wins.
        @(negedge clk);
        load_val(16'h1111, 4'b0000);
        repeat (5) @(negedge clk);
        load_val(16'h2222, 4'b0000);
        grab_frame();
        check_frame("second load", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

        // Decimal point on digit 2.
        load_val(16'h8888, 4'b0100);
        grab_frame();
        check_frame("dots", 8'h80, 8'h80, 8'h00, 8'h80);

        // Asynchronous reset mid-slot.
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst seg_n",    32'(seg_n),    32'h0FF);
        check("async rst dig_en_n", 32'(dig_en_n), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post rst blank", 32'(dig_en_n), 32'hF);
        @(negedge clk);
        check("post rst enable d0", 32'(dig_en_n), 32'hE);
        check("post rst seg cleared", 32'(seg_n), 32'h0C0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rv = '0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(2, 0) != 0) rv[4*k +: 4] = 4'($urandom_range(15, 0));
            value = rv;
            dots  = 4'($urandom_range(15, 0));
            load  = ($urandom_range(9, 0) == 0);
            if ($urandom_range(49, 0) == 0) lz_suppress = ~lz_suppress;
            @(negedge clk);
        end
        load = 1'b0;
        repeat (4) @(negedge clk);
        chk_on = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
